// File: rtl/bcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_ctrl_pkg
//  Description : Shared types and constants for the BCD speed controller:
//                FSM state encoding, default slow-mode divide ratio and the
//                largest legal BCD digit, plus a two-digit validity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned c_DIV_SLOW_DEFAULT = 4;
    localparam logic [3:0]  c_BCD_DIGIT_MAX    = 4'd9;

    // True when both nibbles of a two-digit BCD value are 0..9.
    function automatic logic bcd_valid(input logic [7:0] value);
        return (value[7:4] <= c_BCD_DIGIT_MAX) && (value[3:0] <= c_BCD_DIGIT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_tick_gen
//  Description : Prescaler and tick-enable generator. In fast mode every
//                cycle is a tick; in slow mode a tick occurs when the
//                prescaler reaches DIV_SLOW-1.
//  Ports       : clk, rst (async, active-low)
//                run        - controller is (or will be) in RUN next cycle
//                speed      - currently applied speed (0 fast, 1 slow)
//                speed_load - speed register loads this cycle
//                tick       - clock-enable for the controlled counter
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_tick_gen #(
    parameter int unsigned DIV_SLOW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic speed,
    input  logic speed_load,
    output logic tick
);

    // 4 bits covers the largest legal DIV_SLOW of 16.
    localparam logic [3:0] c_PSC_MAX = 4'(DIV_SLOW - 1);

    logic [3:0] r_psc;

    // The prescaler restarts whenever the applied speed is (re)loaded, so a
    // speed change always begins a fresh slow period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psc <= 4'd0;
        end else if (!run || speed_load) begin
            r_psc <= 4'd0;
        end else if (speed) begin
            r_psc <= r_psc + 4'd1;
        end
    end

    assign tick = !speed || (r_psc == c_PSC_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_speed_ctrl
//  Description : Two-state run controller for an external two-digit BCD
//                counter. Issues increment / clear enables at a fast or
//                slow tick rate, detects the terminal value and either
//                stops or wraps. The clock itself is never gated.
//  Ports       : clk, rst (async, active-low)
//                start/stop/clear - one-cycle control pulses (clear > stop > start)
//                sel              - requested speed, mode_wrap - wrap at target
//                target, cnt_val  - BCD terminal value and current count
//                cnt_en, cnt_clr  - counter enables; busy, done, speed, err
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_speed_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIV_SLOW = c_DIV_SLOW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       sel,
    input  logic       mode_wrap,
    input  logic [7:0] target,
    input  logic [7:0] cnt_val,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       busy,
    output logic       done,
    output logic       speed,
    output logic       err
);

    state_t r_state;
    state_t w_state_next;
    logic   r_speed;
    logic   r_err;

    logic   w_run;
    logic   w_tick;
    logic   w_at_target;
    logic   w_start_req;
    logic   w_active;
    logic   w_speed_load;
    logic   w_next_run;

    assign w_run       = (r_state == RUN);
    assign w_at_target = (cnt_val == target);

    // A start only counts when no higher-priority pulse is present.
    assign w_start_req = start && !clear && !stop;

    // A tick cycle in RUN that is not being aborted by clear or stop.
    assign w_active = w_run && w_tick && !clear && !stop;

    // Speed follows sel freely while idle, but only changes on tick
    // boundaries while running so a slow period is never cut short.
    assign w_speed_load = !w_run || w_tick;
    assign w_next_run   = (w_state_next == RUN);

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else if (w_run) begin
            if (stop || (w_active && w_at_target && !mode_wrap)) begin
                w_state_next = IDLE;
            end
        end else if (w_start_req && bcd_valid(target)) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_speed <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_speed_load) begin
                r_speed <= sel;
            end
            if (clear) begin
                r_err <= 1'b0;
            end else if (w_start_req && !bcd_valid(target)) begin
                r_err <= 1'b1;
            end
        end
    end

    bcd_tick_gen #(
        .DIV_SLOW   (DIV_SLOW)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (w_next_run),
        .speed      (r_speed),
        .speed_load (w_speed_load),
        .tick       (w_tick)
    );

    assign cnt_en  = w_active && !w_at_target;
    assign done    = w_active && w_at_target;
    // clear is the only path to cnt_clr outside RUN; it is masked during
    // reset so every output is quiet while rst is held low.
    assign cnt_clr = (clear && rst) || done;
    assign busy    = w_run;
    assign speed   = r_speed;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_speed_ctrl
//  Description : Self-checking bench for bcd_speed_ctrl. A behavioural BCD
//                counter closes the loop through cnt_en / cnt_clr; expected
//                output vectors {cnt_en, cnt_clr, done, busy, speed, err}
//                are queued with each stimulus cycle and compared on pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       sel = 1'b0;
    logic       mode_wrap = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] cnt_val;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       speed;
    logic       err;

    logic [7:0] r_cnt = 8'h00;
    logic [5:0] sb[$];
    logic [5:0] w_obs;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    bcd_speed_ctrl #(
        .DIV_SLOW  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .sel       (sel),
        .mode_wrap (mode_wrap),
        .target    (target),
        .cnt_val   (cnt_val),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .speed     (speed),
        .err       (err)
    );

    assign w_obs   = {cnt_en, cnt_clr, done, busy, speed, err};
    assign cnt_val = r_cnt;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Controlled counter: not touched by the controller's reset.
    always @(posedge clk) begin
        if (cnt_clr) r_cnt <= 8'h00;
        else if (cnt_en) r_cnt <= bcd_inc(r_cnt);
    end

    // Apply one cycle of stimulus at the falling edge and queue the output
    // vector expected for that cycle.
    task automatic drive(input logic st, input logic sp, input logic cl,
                         input logic sl, input logic wr, input logic [7:0] tg,
                         input logic [5:0] e);
        @(negedge clk);
        start = st; stop = sp; clear = cl; sel = sl; mode_wrap = wr; target = tg;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        drive(1, 0, 1, 0, 0, 8'h05, 6'b000000);
        e = sb.pop_front(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL reset: got %b want %b", w_obs, e); end
        rst = 1'b1;
    endtask

    task automatic test_fast();
        logic [5:0] e;
        logic [5:0] tbl[9] = '{6'b010000, 6'b000000, 6'b100100, 6'b100100, 6'b100100,
                               6'b100100, 6'b100100, 6'b011100, 6'b000000};
        for (int k = 0; k < 9; k++) begin
            drive(k == 1, 0, k == 0, 0, 0, 8'h05, tbl[k]);
            e = sb.pop_front(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL fast c%0d: got %b want %b", k, w_obs, e); end
        end
    endtask

    task automatic test_slow();
        logic [5:0] e;
        drive(0, 0, 1, 1, 0, 8'h02, 6'b010000);
        e = sb.pop_front(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL slow clr: got %b want %b", w_obs, e); end
        drive(1, 0, 0, 1, 0, 8'h02, 6'b000010);
        e = sb.pop_front(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL slow start: got %b want %b", w_obs, e); end
        for (int k = 1; k <= 13; k++) begin
            logic [5:0] x;
            if (k == 13)                x = 6'b000010;
            else if (k == 12)           x = 6'b011110;
            else if (k == 4 || k == 8)  x = 6'b100110;
            else                        x = 6'b000110;
            drive(0, 0, 0, 1, 0, 8'h02, x);
            e = sb.pop_front(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL slow c%0d: got %b want %b", k, w_obs, e); end
        end
    endtask

    task automatic test_speed_switch();
        logic [5:0] e;
        logic [5:0] tbl[10] = '{6'b010010, 6'b000010, 6'b000110, 6'b000110, 6'b000110,
                                6'b100110, 6'b100100, 6'b100100, 6'b000100, 6'b000000};
        for (int k = 0; k < 10; k++) begin
            // sel drops to 0 in the cycle where the prescaler sits at 1
            drive(k == 1, k == 8, k == 0, (k < 3), 0, 8'h99, tbl[k]);
            e = sb.pop_front(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL speed_sw c%0d: got %b want %b", k, w_obs, e); end
        end
    endtask

    task automatic test_priority();
        logic [5:0] e;
        logic [5:0] tbl[6] = '{6'b010000, 6'b000000, 6'b100100, 6'b100100, 6'b010100, 6'b000000};
        for (int k = 0; k < 6; k++) begin
            drive(k == 1 || k == 4, k == 4, k == 0 || k == 4, 0, 0, 8'h99, tbl[k]);
            e = sb.pop_front(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL priority c%0d: got %b want %b", k, w_obs, e); end
        end
    endtask

    task automatic test_err();
        logic [5:0] e;
        logic [7:0] tg[7] = '{8'h1A, 8'h1A, 8'h1A, 8'h1A, 8'hA0, 8'hA0, 8'hA0};
        logic [5:0] tbl[7] = '{6'b000000, 6'b000001, 6'b010001, 6'b000000,
                               6'b000000, 6'b000001, 6'b010001};
        for (int k = 0; k < 7; k++) begin
            drive(k == 0 || k == 4, 0, k == 2 || k == 6, 0, 0, tg[k], tbl[k]);
            e = sb.pop_front(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL err c%0d: got %b want %b", k, w_obs, e); end
        end
    endtask

    task automatic test_wrap_reset();
        logic [5:0] e;
        int         dones = 0;
        drive(0, 0, 1, 0, 1, 8'h99, 6'b010000);
        e = sb.pop_front(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL wrap clr: got %b want %b", w_obs, e); end
        drive(1, 0, 0, 0, 1, 8'h99, 6'b000000);
        e = sb.pop_front(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL wrap start: got %b want %b", w_obs, e); end
        for (int t = 1; t <= 237; t++) begin
            logic term;
            term = ((t % 100) == 0);
            drive(0, 0, 0, 0, 1, 8'h99, {!term, term, term, 3'b100});
            e = sb.pop_front(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL wrap t%0d: got %b want %b", t, w_obs, e); end
            if (done) dones++;
        end
        total++;
        if (dones !== 2) begin bad++; $display("FAIL wrap dones: got %0d want 2", dones); end
        // Reset asserted mid-run, away from any clock edge.
        drive(0, 0, 0, 1, 1, 8'h99, 6'b000000);
        #2 rst = 1'b0;
        #1;
        e = sb.pop_front(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL wrap rst: got %b want %b", w_obs, e); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fast();
        test_slow();
        test_speed_switch();
        test_priority();
        test_err();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_speed_ctrl.md
BCD_SPEED_CTRL -- requirements
Module: bcd_speed_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_SLOW, default 4, meaning the slow-mode tick period in clk cycles (legal 2..16).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begin counting.
REQ-005 stop  input  1  one-cycle pulse; halt counting, count value retained.
REQ-006 clear  input  1  one-cycle pulse; abort and zero the counter.
REQ-007 sel  input  1  requested speed: 0 = fast (tick every cycle), 1 = slow (tick every DIV_SLOW cycles).
REQ-008 mode_wrap  input  1  1 = wrap to 00 at target and keep running; 0 = stop at target.
REQ-009 target  input  8  two-digit BCD terminal value {tens, ones}.
REQ-010 cnt_val  input  8  current two-digit BCD value from the controlled counter.
REQ-011 cnt_en  output  1  counter increment enable.
REQ-012 cnt_clr  output  1  counter synchronous clear.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse on reaching target.
REQ-015 speed  output  1  speed currently applied (not requested).
REQ-016 err  output  1  sticky flag for an invalid target.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and RUN; busy = (state == RUN).
REQ-018 Speed SHALL be applied through clock enables only; the clock SHALL never be gated, divided or muxed.
REQ-019 A prescaler psc SHALL count 0..DIV_SLOW-1 in RUN while speed = 1; tick = (speed == 0) or (psc == DIV_SLOW-1).
REQ-020 In RUN on a tick cycle: if cnt_val == target, assert cnt_clr and done (not cnt_en); otherwise assert cnt_en.
REQ-021 cnt_en, cnt_clr and done SHALL be 0 in IDLE, except for cnt_clr on a clear pulse.
REQ-022 On a terminal tick with mode_wrap = 0, the FSM SHALL go to IDLE on the next edge; with mode_wrap = 1 it SHALL stay in RUN.
REQ-023 speed SHALL load from sel in IDLE every cycle, and in RUN only on a tick cycle; psc SHALL reset to 0 whenever speed loads.
REQ-024 Pulse priority SHALL be clear > stop > start.
REQ-025 clear in any state SHALL assert cnt_clr combinationally that cycle, force IDLE, zero psc and clear err.
REQ-026 stop in RUN SHALL suppress cnt_en that cycle and force IDLE; stop in IDLE SHALL be a no-op.
REQ-027 start in IDLE SHALL enter RUN on the next edge with psc = 0.
REQ-028 The first cnt_en SHALL occur 1 cycle after the start pulse in fast mode and DIV_SLOW cycles after it in slow mode.
REQ-029 start in RUN SHALL be ignored.
REQ-030 start while either target nibble > 9 SHALL be ignored and SHALL set err.
REQ-031 target == 00 SHALL give a terminal event on every tick (cnt_clr + done).

Reset
REQ-032 Asserting rst SHALL immediately force state = IDLE, psc = 0, speed = 0 and err = 0.
REQ-033 Asserting rst SHALL immediately force cnt_en = 0, cnt_clr = 0, busy = 0 and done = 0.
REQ-034 Reset asserted mid-RUN SHALL abort with no partial tick; the counter value is not cleared by this block.

Structure
REQ-035 A shared package bcd_ctrl_pkg SHALL hold the state enum (IDLE, RUN), the DIV_SLOW default and the BCD digit-max constant 4'd9.
REQ-036 The prescaler/tick generator SHALL be one sub-module, bcd_tick_gen (inputs: run, speed, speed_load; output: tick).
REQ-037 The total RTL SHALL be 120-400 lines.

Verification
REQ-038 The bench SHALL check: sel = 0, target = 8'h05, mode_wrap = 0, start -> cnt_en on 5 consecutive cycles, then cnt_clr + done at cnt_val = 05, then IDLE.
REQ-039 The bench SHALL check: sel = 1, DIV_SLOW = 4, target = 8'h02, start -> cnt_en at cycles 4 and 8, cnt_clr + done at cycle 12.
REQ-040 The bench SHALL check: sel toggles 1 -> 0 at psc = 1 in RUN -> speed stays 1 until the next tick, then ticks every cycle.
REQ-041 The bench SHALL check: start, stop and clear asserted together in RUN -> cnt_clr = 1, cnt_en = 0, IDLE next cycle.
REQ-042 The bench SHALL check: target = 8'h1A, start -> stays IDLE, err = 1; a clear pulse -> err = 0.
REQ-043 The bench SHALL check: mode_wrap = 1, target = 8'h99, fast mode -> done every 100 ticks; rst low mid-run -> all outputs 0 immediately.
